image_read: RTL and testbench

IMAGE_READ -- requirements
Module: image_read

---
 rtl/image_read.sv | 166 ++++++++++++++++
 tb/tb_image_read.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/image_read.sv
// Streams a raw B,G,R pixel image from a preloaded ROM as timed rows framed by HSYNC.
// Optional 3x3 Gaussian filter datapath is built when GAUSSIAN_BLUR_EN is defined.
module image_read #(
    parameter     INFILE         = "input.hex",
    parameter int WIDTH          = 768,
    parameter int HEIGHT         = 512,
    parameter int START_UP_DELAY = 100,
    parameter int HSYNC_DELAY    = 160
) (
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       mode,
    output logic       HSYNC,
    output logic [7:0] DATA_R,
    output logic [7:0] DATA_G,
    output logic [7:0] DATA_B
);
    localparam int DEPTH = WIDTH * HEIGHT * 3;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = $clog2(WIDTH + 1);
    localparam int RW    = $clog2(HEIGHT + 1);
    localparam int DMAX  = (START_UP_DELAY > HSYNC_DELAY) ? START_UP_DELAY : HSYNC_DELAY;
    localparam int NW    = $clog2(DMAX + 1);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACTIVE, S_BLANK, S_DONE} state_t;

    logic [7:0] mem [0:DEPTH-1];

    state_t        state_q, state_d;
    logic [NW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          hsync_q;
    logic [7:0]    r_q, g_q, b_q;
    logic [7:0]    pix [3];

    function automatic logic [AW-1:0] addr_of(input logic [RW-1:0] r, input logic [CW-1:0] c,
                                              input int ch);
        return AW'((int'(r) * WIDTH + int'(c)) * 3 + ch);
    endfunction

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            col_q   <= col_d;
            row_q   <= row_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        col_d   = col_q;
        row_d   = row_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            S_WAIT: begin
                if (cnt_q == NW'(START_UP_DELAY - 1)) begin
                    state_d = S_ACTIVE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_ACTIVE: begin
                if (col_q == CW'(WIDTH - 1)) begin
                    col_d = '0;
                    // The last row ends the frame without a trailing blank interval.
                    if (row_q == RW'(HEIGHT - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        row_d   = row_q + 1'b1;
                        state_d = S_BLANK;
                        cnt_d   = '0;
                    end
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            S_BLANK: begin
                if (cnt_q == NW'(HSYNC_DELAY - 1)) begin
                    state_d = S_ACTIVE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

`ifdef GAUSSIAN_BLUR_EN
    logic [RW-1:0] rn [3];
    logic [CW-1:0] cn [3];

    // Neighbour coordinates clamp to the image edge.
    always_comb begin
        rn[0] = (row_q == '0) ? row_q : row_q - 1'b1;
        rn[1] = row_q;
        rn[2] = (row_q == RW'(HEIGHT - 1)) ? row_q : row_q + 1'b1;
        cn[0] = (col_q == '0) ? col_q : col_q - 1'b1;
        cn[1] = col_q;
        cn[2] = (col_q == CW'(WIDTH - 1)) ? col_q : col_q + 1'b1;
    end
`else
    logic unused_mode;
    assign unused_mode = mode;
`endif

    // Channel 0 = B, 1 = G, 2 = R, matching the byte order in the file.
    for (genvar gi = 0; gi < 3; gi++) begin : g_ch
        logic [7:0] raw;
        assign raw = mem[addr_of(row_q, col_q, gi)];
`ifdef GAUSSIAN_BLUR_EN
        logic [11:0] acc;
        always_comb begin
            acc = '0;
            for (int dr = 0; dr < 3; dr++) begin
                for (int dc = 0; dc < 3; dc++) begin
                    acc = acc + (12'(mem[addr_of(rn[dr], cn[dc], gi)])
                                 << ((dr == 1 ? 1 : 0) + (dc == 1 ? 1 : 0)));
                end
            end
        end
        assign pix[gi] = mode ? acc[11:4] : raw;
`else
        assign pix[gi] = raw;
`endif
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            hsync_q <= 1'b0;
            b_q     <= '0;
            g_q     <= '0;
            r_q     <= '0;
        end else begin
            hsync_q <= (state_q == S_ACTIVE);
            if (state_q == S_ACTIVE) begin
                b_q <= pix[0];
                g_q <= pix[1];
                r_q <= pix[2];
            end else begin
                b_q <= '0;
                g_q <= '0;
                r_q <= '0;
            end
        end
    end

    assign HSYNC  = hsync_q;
    assign DATA_B = b_q;
    assign DATA_G = g_q;
    assign DATA_R = r_q;

endmodule

// File: tb/tb_image_read.sv
// Directed bench for image_read on a 3x3 image with short start-up and blanking delays.
module tb_image_read;
    localparam int W   = 3;
    localparam int H   = 3;
    localparam int SUD = 4;
    localparam int HD  = 2;
    localparam int NCY = 24;

    logic       HCLK = 1'b0;
    logic       HRESETn;
    logic       mode;
    logic       HSYNC;
    logic [7:0] DATA_R, DATA_G, DATA_B;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] eb [9];
    logic [7:0] eg [9];
    logic [7:0] er [9];

    image_read #(
        .INFILE(""), .WIDTH(W), .HEIGHT(H), .START_UP_DELAY(SUD), .HSYNC_DELAY(HD)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .mode(mode),
        .HSYNC(HSYNC), .DATA_R(DATA_R), .DATA_G(DATA_G), .DATA_B(DATA_B)
    );

    always #10 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %06h expected %06h", tag, got, exp);
        end
    endtask

    // kind 0: ramp bytes 0x10+k; 1: single 0xFF centre pixel; 2: all bytes 0x80
    task automatic load_image(input int kind);
        for (int k = 0; k < W * H * 3; k++) begin
            case (kind)
                0:       dut.mem[k] = 8'(8'h10 + k);
                1:       dut.mem[k] = (k / 3 == 4) ? 8'hFF : 8'h00;
                default: dut.mem[k] = 8'h80;
            endcase
        end
    endtask

    function automatic logic exp_hsync(input int e);
        for (int r = 0; r < H; r++) begin
            int st;
            st = SUD + 2 + r * (W + HD);
            if (e >= st && e < st + W) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Edge 1 is the first rising edge after reset release.
    task automatic run_frame(input string name, input logic m);
        int p;
        logic eh;
        p = 0;
        mode = m;
        @(negedge HCLK);
        HRESETn = 1'b1;
        for (int e = 1; e <= NCY; e++) begin
            @(posedge HCLK);
            #1;
            eh = exp_hsync(e);
            check($sformatf("%s_hsync_e%0d", name, e), {23'd0, HSYNC}, {23'd0, eh});
            if (eh && p < 9) begin
                check($sformatf("%s_pix%0d", name, p), {DATA_R, DATA_G, DATA_B},
                      {er[p], eg[p], eb[p]});
                p++;
            end else begin
                check($sformatf("%s_zero_e%0d", name, e), {DATA_R, DATA_G, DATA_B}, 24'd0);
            end
        end
        check({name, "_npix"}, 24'(p), 24'd9);
    endtask

    task automatic enter_reset;
        @(negedge HCLK);
        HRESETn = 1'b0;
    endtask

    initial begin
        logic [7:0] blur_tab [9];
        logic [7:0] ctr_raw  [9];
        blur_tab = '{8'h0F, 8'h1F, 8'h0F, 8'h1F, 8'h3F, 8'h1F, 8'h0F, 8'h1F, 8'h0F};
        ctr_raw  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
        HRESETn = 1'b0;
        mode    = 1'b0;

        // Raw ramp image: byte order B,G,R per pixel.
        load_image(0);
        repeat (3) @(negedge HCLK);
        check("reset_hsync", {23'd0, HSYNC}, 24'd0);
        check("reset_data", {DATA_R, DATA_G, DATA_B}, 24'd0);
        for (int p = 0; p < 9; p++) begin
            eb[p] = 8'(8'h10 + 3 * p);
            eg[p] = 8'(8'h11 + 3 * p);
            er[p] = 8'(8'h12 + 3 * p);
        end
        run_frame("raw_ramp", 1'b0);

        // Centre impulse, filtered (raw when the filter is not built).
        enter_reset();
        load_image(1);
        for (int p = 0; p < 9; p++) begin
`ifdef GAUSSIAN_BLUR_EN
            eb[p] = blur_tab[p];
`else
            eb[p] = ctr_raw[p];
`endif
            eg[p] = eb[p];
            er[p] = eb[p];
        end
        run_frame("impulse_m1", 1'b1);

        // Same image, mode 0: raw bytes.
        enter_reset();
        for (int p = 0; p < 9; p++) begin
            eb[p] = ctr_raw[p];
            eg[p] = ctr_raw[p];
            er[p] = ctr_raw[p];
        end
        run_frame("impulse_m0", 1'b0);

        // Constant 0x80 image stays 0x80 everywhere, corners included.
        enter_reset();
        load_image(2);
        for (int p = 0; p < 9; p++) begin
            eb[p] = 8'h80;
            eg[p] = 8'h80;
            er[p] = 8'h80;
        end
        run_frame("const80_m1", 1'b1);

        // Reset in the middle of row 1, then restart from pixel (0,0).
        enter_reset();
        load_image(0);
        for (int p = 0; p < 9; p++) begin
            eb[p] = 8'(8'h10 + 3 * p);
            eg[p] = 8'(8'h11 + 3 * p);
            er[p] = 8'(8'h12 + 3 * p);
        end
        mode = 1'b0;
        @(negedge HCLK);
        HRESETn = 1'b1;
        repeat (SUD + 2 + W + HD + 1) @(posedge HCLK);
        #1;
        check("midrow_hsync", {23'd0, HSYNC}, 24'd1);
        check("midrow_pix4", {DATA_R, DATA_G, DATA_B}, {er[4], eg[4], eb[4]});
        #4;
        HRESETn = 1'b0;
        #1;
        check("abort_hsync", {23'd0, HSYNC}, 24'd0);
        check("abort_data", {DATA_R, DATA_G, DATA_B}, 24'd0);
        run_frame("restart", 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
